// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write-port sharing logic:
// bank geometry, requester indices and the write request record.
package regbank_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Bus bundle between the writeback requesters, the bank write port and
// the read-address forwarding path.
interface regbank_write_arbiter_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              regWriteEnable;
    logic [ADDR_W-1:0] regWriteAddr;
    logic [DATA_W-1:0] regWriteData;

    logic [ADDR_W-1:0] regAddr_1;
    logic [ADDR_W-1:0] regAddr_2;
    logic              fwdValid_1;
    logic              fwdValid_2;
    logic [DATA_W-1:0] fwdData_1;
    logic [DATA_W-1:0] fwdData_2;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output regAddr_1, regAddr_2,
        input  req0_ready, req1_ready, regWriteEnable, regWriteAddr, regWriteData,
        input  fwdValid_1, fwdValid_2, fwdData_1, fwdData_2
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  regAddr_1, regAddr_2,
        output req0_ready, req1_ready, regWriteEnable, regWriteAddr, regWriteData,
        output fwdValid_1, fwdValid_2, fwdData_1, fwdData_2
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer records the last accepted
// requester and only moves on an accept strobe.
module rr_arbiter2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output logic       last_o
);
    logic last_q;
    logic last_d;

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (req_i == 2'b11) begin
                grant_o[REQ_ALU] = last_q;
                grant_o[REQ_MEM] = ~last_q;
            end else begin
                grant_o = req_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = grant_o[REQ_MEM];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;
endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register-bank write port between the ALU and memory writeback
// paths, with a registered write stage, in-flight forwarding and a debug counter.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    regbank_write_arbiter_if.slave bus,
    output logic                   last_grant_o,
    output logic [CNT_W-1:0]       write_count_o
);
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fwd1, fwd2;

    assign req = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .enable_i (rst & ~stall_i),
        .req_i    (req),
        .accept_i (xfer),
        .grant_o  (grant),
        .last_o   (last_grant_o)
    );

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign xfer           = |grant;
    assign bus.req0_ready = grant[REQ_ALU];
    assign bus.req1_ready = grant[REQ_MEM];

    always_comb begin
        sel_addr = grant[REQ_MEM] ? bus.req1_addr : bus.req0_addr;
        sel_data = grant[REQ_MEM] ? bus.req1_data : bus.req0_data;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (xfer) begin
            we_d    = (sel_addr != '0);
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
        cnt_d = cnt_q;
        if (we_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd1 = we_q && (waddr_q == bus.regAddr_1);
    assign fwd2 = we_q && (waddr_q == bus.regAddr_2);

    assign bus.regWriteEnable = we_q;
    assign bus.regWriteAddr   = waddr_q;
    assign bus.regWriteData   = wdata_q;
    assign bus.fwdValid_1     = fwd1;
    assign bus.fwdValid_2     = fwd2;
    assign bus.fwdData_1      = fwd1 ? wdata_q : '0;
    assign bus.fwdData_2      = fwd2 ? wdata_q : '0;
    assign write_count_o      = cnt_q;
endmodule
